flow_led_ctrl: RTL and testbench



---
 rtl/flow_led_pkg.sv | 15 +
 rtl/flow_led_tick.sv | 41 ++++
 rtl/flow_led_ctrl.sv | 57 +++++
 tb/tb_flow_led_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/flow_led_pkg.sv
// Shared widths, reset pattern and helpers for the four-LED running light.
package flow_led_pkg;

  localparam int LED_W = 4;
  localparam int CNT_W = 24;

  typedef logic [LED_W-1:0] led_t;

  localparam led_t LED_INIT = 4'b0001;

  function automatic led_t led_rotl(input led_t pat);
    return {pat[LED_W-2:0], pat[LED_W-1]};
  endfunction

endpackage

// File: rtl/flow_led_tick.sv
// Free-running prescaler: counts 0..CNT_MAX and emits a registered one-cycle
// step tick in the cycle after the count reaches CNT_MAX.
module flow_led_tick
  import flow_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 24'd24_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cnt_flag_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_flag_q, cnt_flag_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    cnt_flag_d = at_max;
    if (at_max) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      cnt_flag_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cnt_flag_q <= cnt_flag_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_flag_o = cnt_flag_q;

endmodule

// File: rtl/flow_led_ctrl.sv
// Four-LED running light: one-hot pattern rotates left on every prescaler tick.
// Define FLOW_LED_ACTIVE_LOW_EN for boards whose LEDs are tied to VCC.
module flow_led_ctrl
  import flow_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = 24'd24_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  output logic [LED_W-1:0] led
);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick_flag;
  led_t             led_r_q, led_r_d;
  led_t             led_q, led_d;
  led_t             led_rst;

  flow_led_tick #(
    .CNT_MAX (CNT_MAX)
  ) u_tick (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cnt_o      (tick_cnt),
    .cnt_flag_o (tick_flag)
  );

  always_comb begin
    led_r_d = led_r_q;
    if (tick_flag) begin
      led_r_d = led_rotl(led_r_q);
    end
  end

  // The pin register loads the same next pattern as led_r, so the pins
  // come straight from flops with no decode between flop and pad.
`ifdef FLOW_LED_ACTIVE_LOW_EN
  assign led_d   = ~led_r_d;
  assign led_rst = ~LED_INIT;
`else
  assign led_d   = led_r_d;
  assign led_rst = LED_INIT;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_r_q <= LED_INIT;
      led_q   <= led_rst;
    end else begin
      led_r_q <= led_r_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Directed bench for flow_led_ctrl: reset, step timing, wrap, mid-run reset,
// CNT_MAX = 0; expected pin polarity follows FLOW_LED_ACTIVE_LOW_EN.
module tb_flow_led_ctrl;

  logic       sys_clk;
  logic       rst_n;
  logic       rst0_n;
  logic [3:0] led;
  logic [3:0] led0;

  int tests_run = 0;
  int tests_failed = 0;
  int n_main = 0;
  int n_zero = 0;
  time last_change = 0;
  logic [3:0] prev_led;

  flow_led_ctrl #(.CNT_MAX(24'd24)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (rst_n),
    .led       (led)
  );

  flow_led_ctrl #(.CNT_MAX(24'd0)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (rst0_n),
    .led       (led0)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one-hot pattern after n edges since release, step period m+1
  function automatic logic [3:0] exp_pat(input int m, input int n);
    int c;
    logic [3:0] p;
    c = (n >= m + 2) ? ((n - (m + 2)) / (m + 1) + 1) : 0;
    p = 4'b0001;
    for (int i = 0; i < (c % 4); i++) p = {p[2:0], p[3]};
    return p;
  endfunction

  function automatic logic [3:0] pin(input logic [3:0] p);
`ifdef FLOW_LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic run_main(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge sys_clk);
      #1;
      n_main++;
      check("main_led", 32'(led), 32'(pin(exp_pat(24, n_main))));
      check("main_cnt", dut.tick_cnt, 32'(n_main % 25));
      check("main_flag", 32'(dut.tick_flag), 32'((n_main > 0) && (n_main % 25 == 0)));
      check("main_onehot", $countones(dut.led_r_q), 1);
      if (led !== prev_led) begin
        if (last_change != 0) check("step_period", 32'($time - last_change), 32'd500);
        last_change = $time;
      end
      prev_led = led;
    end
  endtask

  task automatic run_zero(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge sys_clk);
      #1;
      n_zero++;
      check("zero_led", 32'(led0), 32'(pin(exp_pat(0, n_zero))));
      check("zero_cnt", dut0.tick_cnt, 0);
      check("zero_flag", 32'(dut0.tick_flag), 32'(n_zero > 0));
      check("zero_onehot", $countones(dut0.led_r_q), 1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst0_n = 1'b0;
    // reset held for 200 ns
    for (int i = 0; i < 9; i++) begin
      @(negedge sys_clk);
      check("rst_led", 32'(led), 32'(pin(4'b0001)));
      check("rst_cnt", dut.tick_cnt, 0);
      check("rst_flag", 32'(dut.tick_flag), 0);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    prev_led = led;
    // first step after 26 edges, then 5 steps covering the wrap
    run_main(25);
    check("before_first_step", 32'(led), 32'(pin(4'b0001)));
    run_main(1);
    check("first_step", 32'(led), 32'(pin(4'b0010)));
    check("first_step_time", 32'($time), 32'd711);
    run_main(100);
    check("wrap_led", 32'(led), 32'(pin(4'b0010)));

    // fresh start, then reset while led = 0100 and cnt = 13
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    n_main = 0;
    last_change = 0;
    prev_led = led;
    run_main(63);
    check("pre_rst_led", 32'(led), 32'(pin(4'b0100)));
    check("pre_rst_cnt", dut.tick_cnt, 13);
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'(pin(4'b0001)));
    check("async_rst_cnt", dut.tick_cnt, 0);
    check("async_rst_flag", 32'(dut.tick_flag), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    n_main = 0;
    last_change = 0;
    prev_led = led;
    run_main(25);
    check("rerun_hold", 32'(led), 32'(pin(4'b0001)));
    run_main(1);
    check("rerun_step", 32'(led), 32'(pin(4'b0010)));

    // CNT_MAX = 0: rotate every edge after the first tick
    @(negedge sys_clk);
    check("zero_rst_led", 32'(led0), 32'(pin(4'b0001)));
    rst0_n = 1'b1;
    run_zero(12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
